// File: rtl/bf16_sub_pipe.sv
// Three-stage pipelined bfloat16 subtractor c = a - b with valid/ready handshake and a pass-through tag.
// Rounds toward zero; subnormal operands and results are flushed to zero.
module bf16_sub_pipe #(
  parameter int E     = 8,
  parameter int M     = 7,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             sa_i,
  input  logic [E-1:0]     ea_i,
  input  logic [M-1:0]     ma_i,
  input  logic             sb_i,
  input  logic [E-1:0]     eb_i,
  input  logic [M-1:0]     mb_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [TAG_W-1:0] tag_o,
  output logic             s_o,
  output logic [E-1:0]     e_o,
  output logic [M-1:0]     m_o
);
  localparam int SW  = M + 4;  // hidden | mantissa | guard | round | sticky
  localparam int SHW = $clog2(SW + 2);
  localparam int PW  = 1 + E + M;
  localparam logic [E-1:0]  EMAX = '1;
  localparam logic [E-1:0]  EFIN = {{(E-1){1'b1}}, 1'b0};
  localparam logic [PW-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  logic en;
  assign en      = ~valid_o | ready_i;
  assign ready_o = en;

  logic           sb_eff, a_zero, b_zero, a_inf, b_inf, swap;
  logic           sx_c, sy_c;
  logic [E-1:0]   ex_c, ey_c, ediff_c;
  logic [M-1:0]   mx_c, my_c;
  logic [SHW-1:0] shamt_c;
  logic [SW-1:0]  sig_y_c, shifted_c, lost_mask_c, ay_c;
  logic           spec_c;
  logic [PW-1:0]  spec_val_c;

  always_comb begin
    sb_eff  = ~sb_i;
    a_zero  = (ea_i == '0);
    b_zero  = (eb_i == '0);
    a_inf   = (ea_i == EMAX);
    b_inf   = (eb_i == EMAX);
    swap    = (eb_i > ea_i) || ((eb_i == ea_i) && (mb_i > ma_i));
    sx_c    = swap ? sb_eff : sa_i;
    sy_c    = swap ? sa_i : sb_eff;
    ex_c    = swap ? eb_i : ea_i;
    ey_c    = swap ? ea_i : eb_i;
    mx_c    = swap ? mb_i : ma_i;
    my_c    = swap ? ma_i : mb_i;
    ediff_c = ex_c - ey_c;
    // Any shift past the field collapses to "everything is sticky".
    shamt_c     = (ediff_c > E'(SW)) ? SHW'(SW + 1) : ediff_c[SHW-1:0];
    sig_y_c     = {1'b1, my_c, 3'b000};
    shifted_c   = sig_y_c >> shamt_c;
    lost_mask_c = ~({SW{1'b1}} << shamt_c);
    ay_c        = {shifted_c[SW-1:1], shifted_c[0] | (|(sig_y_c & lost_mask_c))};

    spec_c     = 1'b1;
    spec_val_c = '0;
    if (a_inf && b_inf)
      spec_val_c = (sa_i == sb_i) ? QNAN : {sa_i, EMAX, {M{1'b0}}};
    else if (a_inf)
      spec_val_c = {sa_i, EMAX, {M{1'b0}}};
    else if (b_inf)
      spec_val_c = {sb_eff, EMAX, {M{1'b0}}};
    else if (a_zero && b_zero)
      spec_val_c = {sa_i & sb_eff, {(E+M){1'b0}}};
    else if (b_zero)
      spec_val_c = {sa_i, ea_i, ma_i};
    else if (a_zero)
      spec_val_c = {sb_eff, eb_i, mb_i};
    else
      spec_c = 1'b0;
  end

  logic             v1_reg, spec1_reg, sx1_reg, sy1_reg;
  logic [TAG_W-1:0] tag1_reg;
  logic [PW-1:0]    spec_val1_reg;
  logic [E-1:0]     ex1_reg;
  logic [M-1:0]     mx1_reg;
  logic [SW-1:0]    ay1_reg;

  logic [SW-1:0] sig_x_c;
  logic [SW:0]   sum_c;

  always_comb begin
    sig_x_c = {1'b1, mx1_reg, 3'b000};
    sum_c   = (sx1_reg ^ sy1_reg) ? ({1'b0, sig_x_c} - {1'b0, ay1_reg})
                                  : ({1'b0, sig_x_c} + {1'b0, ay1_reg});
  end

  logic             v2_reg, spec2_reg, s2_reg;
  logic [TAG_W-1:0] tag2_reg;
  logic [PW-1:0]    spec_val2_reg;
  logic [E-1:0]     e2_reg;
  logic [SW:0]      sum2_reg;

  logic          found_c;
  int            lz_c, exp_c;
  logic [SW-1:0] norm_c;
  logic [M-1:0]  m_c;
  logic [PW-1:0] res_c;

  always_comb begin
    found_c = 1'b0;
    lz_c    = 0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found_c) begin
        if (sum2_reg[i]) found_c = 1'b1;
        else lz_c = lz_c + 1;
      end
    end
    norm_c = sum2_reg[SW-1:0] << lz_c;
    // Guard/round/sticky are simply dropped: truncation is round-toward-zero.
    if (sum2_reg[SW]) begin
      exp_c = int'(e2_reg) + 1;
      m_c   = M'(sum2_reg >> (SW - M));
    end else begin
      exp_c = int'(e2_reg) - lz_c;
      m_c   = M'(norm_c >> (SW - 1 - M));
    end
    if (spec2_reg)                  res_c = spec_val2_reg;
    else if (sum2_reg == '0)        res_c = '0;
    else if (exp_c <= 0)            res_c = {s2_reg, {(E+M){1'b0}}};
    else if (exp_c >= int'(EMAX))   res_c = {s2_reg, EFIN, {M{1'b1}}};
    else                            res_c = {s2_reg, E'(exp_c), m_c};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg  <= 1'b0;
      v2_reg  <= 1'b0;
      valid_o <= 1'b0;
      tag_o   <= '0;
      s_o     <= 1'b0;
      e_o     <= '0;
      m_o     <= '0;
    end else if (en) begin
      v1_reg        <= valid_i;
      tag1_reg      <= tag_i;
      spec1_reg     <= spec_c;
      spec_val1_reg <= spec_val_c;
      sx1_reg       <= sx_c;
      sy1_reg       <= sy_c;
      ex1_reg       <= ex_c;
      mx1_reg       <= mx_c;
      ay1_reg       <= ay_c;

      v2_reg        <= v1_reg;
      tag2_reg      <= tag1_reg;
      spec2_reg     <= spec1_reg;
      spec_val2_reg <= spec_val1_reg;
      s2_reg        <= sx1_reg;
      e2_reg        <= ex1_reg;
      sum2_reg      <= sum_c;

      valid_o       <= v2_reg;
      tag_o         <= tag2_reg;
      {s_o, e_o, m_o} <= res_c;
    end
  end
endmodule

// File: tb/tb_bf16_sub_pipe.sv
// Scoreboard bench for bf16_sub_pipe: the driver pushes expected results, an independent monitor pops
// and compares on every output transfer. Expected values come from an exact big-integer model.
module tb_bf16_sub_pipe;
  logic       clk = 1'b0;
  logic       rst, valid_i, ready_o, ready_i, valid_o;
  logic [3:0] tag_i, tag_o;
  logic       sa_i, sb_i, s_o;
  logic [7:0] ea_i, eb_i, e_o;
  logic [6:0] ma_i, mb_i, m_o;

  bf16_sub_pipe #(.E(8), .M(7), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .tag_i(tag_i),
    .sa_i(sa_i), .ea_i(ea_i), .ma_i(ma_i), .sb_i(sb_i), .eb_i(eb_i), .mb_i(mb_i),
    .valid_o(valid_o), .ready_i(ready_i), .tag_o(tag_o), .s_o(s_o), .e_o(e_o), .m_o(m_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expv;
    int          cyc;
    bit          lat;
  } sb_t;
  sb_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int rmode    = 0;  // 0: ready high, 1: random, 2: scripted two-cycle drop
  int bp_lo    = 0;

  localparam int ND = 16;
  logic [15:0] da [ND] = '{16'h3F80, 16'h4040, 16'h3F80, 16'h3F80, 16'h3F80, 16'h8000, 16'h0001, 16'h7F80,
                           16'h7F80, 16'h3F80, 16'h7F7F, 16'h0080, 16'h0000, 16'hFF80, 16'h0000, 16'h8000};
  logic [15:0] db [ND] = '{16'h3F80, 16'h3F80, 16'h4040, 16'h3B00, 16'h0000, 16'h0000, 16'h0000, 16'h7F80,
                           16'hFF80, 16'h7F80, 16'hFF7F, 16'h0081, 16'h3F80, 16'h3F80, 16'h8000, 16'h8000};
  logic [15:0] dr [ND] = '{16'h0000, 16'h4000, 16'hC000, 16'h3F7F, 16'h3F80, 16'h8000, 16'h0000, 16'h7FC0,
                           16'h7F80, 16'hFF80, 16'h7F7F, 16'h8000, 16'hBF80, 16'hFF80, 16'h0000, 16'h0000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Exact value of a bf16 number is sig * 2^(e-134); scaling by 2^133 makes every operand an integer.
  function automatic logic [15:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
    logic sa, sb, s;
    int ea, eb, p, be;
    logic signed [299:0] na, nb, d;
    logic [299:0] mag;
    sa = a[15]; sb = b[15];
    ea = int'(a[14:7]); eb = int'(b[14:7]);
    if (ea == 255 && eb == 255) return (sa == sb) ? 16'h7FC0 : {sa, 8'hFF, 7'h00};
    if (ea == 255) return {sa, 8'hFF, 7'h00};
    if (eb == 255) return {~sb, 8'hFF, 7'h00};
    if (ea == 0 && eb == 0) return {sa & ~sb, 15'h0000};
    na = '0; nb = '0;
    if (ea != 0) begin na = 300'({1'b1, a[6:0]}) << (ea - 1); if (sa) na = -na; end
    if (eb != 0) begin nb = 300'({1'b1, b[6:0]}) << (eb - 1); if (sb) nb = -nb; end
    d = na - nb;
    if (d == 0) return 16'h0000;
    s = (d < 0);
    mag = s ? -d : d;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    be = p - 6;
    if (be <= 0) return {s, 15'h0000};
    if (be >= 255) return {s, 8'hFE, 7'h7F};
    return {s, 8'(be), 7'(mag >> (p - 7))};
  endfunction

  function automatic logic [15:0] rand_op(input logic [7:0] near_e, input bit use_near);
    int r, t;
    logic s;
    logic [7:0] e;
    logic [6:0] m;
    r = int'($urandom_range(0, 99));
    s = 1'($urandom);
    m = 7'($urandom);
    if (r < 8) e = 8'h00;
    else if (r < 13) begin e = 8'hFF; m = 7'h00; end
    else if (r < 18) begin
      t = int'($urandom_range(0, 3));
      e = (t < 2) ? 8'(t + 1) : 8'(t + 251);
    end else if (use_near) begin
      t = int'(near_e) + int'($urandom_range(0, 4)) - 2;
      if (t < 1) t = 1;
      if (t > 254) t = 254;
      e = 8'(t);
    end else e = 8'($urandom_range(1, 254));
    return {s, e, m};
  endfunction

  function automatic logic next_ready();
    if (rmode == 1) return ($urandom_range(0, 9) < 7);
    if (rmode == 2) return !(cyc >= bp_lo && cyc < bp_lo + 2);
    return 1'b1;
  endfunction

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = next_ready();
  endtask

  task automatic issue(input logic [3:0] tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] expv, input bit lat);
    int waited;
    sb_t ent;
    @(negedge clk);
    ready_i = next_ready();
    valid_i = 1'b1; tag_i = tag;
    sa_i = a[15]; ea_i = a[14:7]; ma_i = a[6:0];
    sb_i = b[15]; eb_i = b[14:7]; mb_i = b[6:0];
    #1;
    waited = 0;
    while (ready_o !== 1'b1) begin
      waited++;
      if (waited > 200) begin
        n_checks++;
        $display("FAIL accept_timeout: ready_o=%b after %0d cycles, required 1", ready_o, waited);
        valid_i = 1'b0;
        return;
      end
      @(negedge clk);
      ready_i = next_ready();
      #1;
    end
    ent.tag = tag; ent.a = a; ent.b = b; ent.expv = expv; ent.cyc = cyc; ent.lat = lat;
    sb_q.push_back(ent);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin idle(); n++; end
    check("drain_left", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    repeat (4) idle();
  endtask

  // Monitor: one transfer per cycle at most, compared against the head of the scoreboard.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b1) continue;
      if (valid_o === 1'b1 && ready_i === 1'b0) check("stall_ready_o", 32'(ready_o), 32'd0);
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: tag=%0d res=%h, required no output", tag_o, {s_o, e_o, m_o});
        end else begin
          e = sb_q.pop_front();
          $display("tx tag=%0d a=%h b=%h res=%h exp=%h", tag_o, e.a, e.b, {s_o, e_o, m_o}, e.expv);
          check("tag", 32'(tag_o), 32'(e.tag));
          check("result", 32'({s_o, e_o, m_o}), 32'(e.expv));
          if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; tag_i = '0;
    sa_i = 1'b0; ea_i = '0; ma_i = '0; sb_i = 1'b0; eb_i = '0; mb_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_tag_o", 32'(tag_o), 32'd0);
    check("reset_result", 32'({s_o, e_o, m_o}), 32'd0);
    check("reset_ready_o", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    rmode = 0;
    for (int i = 0; i < ND; i++) issue(4'(i), da[i], db[i], dr[i], 1'b1);
    idle();
    drain();

    rmode = 2;
    bp_lo = cyc + 4;
    for (int i = 0; i < 6; i++) begin
      a = rand_op(8'h00, 1'b0);
      b = rand_op(a[14:7], 1'b1);
      issue(4'(i), a, b, ref_sub(a, b), 1'b0);
    end
    idle();
    rmode = 0;
    drain();

    for (int i = 0; i < 3; i++) issue(4'(i + 9), 16'h3F80, 16'h4000, 16'hBF80, 1'b0);
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b0; rst = 1'b1;
    #1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0; ready_i = 1'b1;
    #1;
    check("midrst_valid_o", 32'(valid_o), 32'd0);
    check("midrst_tag_o", 32'(tag_o), 32'd0);
    check("midrst_result", 32'({s_o, e_o, m_o}), 32'd0);
    repeat (6) idle();
    issue(4'd7, 16'h4040, 16'h3F80, 16'h4000, 1'b1);
    idle();
    drain();

    rmode = 1;
    for (int i = 0; i < 10000; i++) begin
      a = rand_op(8'h00, 1'b0);
      b = rand_op(a[14:7], ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 4) == 0) idle();
      issue(4'(i), a, b, ref_sub(a, b), 1'b0);
    end
    idle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
